// File: rtl/serial_sub4_if.sv
// Start/done request bus for the bit-serial 4-bit subtractor.
// The ovf signal is present only when SERIAL_SUB4_OVF_EN is defined.
interface serial_sub4_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       b_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       b_out;
`ifdef SERIAL_SUB4_OVF_EN
  logic       ovf;
`endif

  modport master (
    output start, a, b, b_in,
`ifdef SERIAL_SUB4_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, b_out
  );

  modport slave (
    input  start, a, b, b_in,
`ifdef SERIAL_SUB4_OVF_EN
    output ovf,
`endif
    output busy, done, diff, b_out
  );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB4_OVF_EN.
module serial_sub4 (
  input logic          clk,
  input logic          rst,
  serial_sub4_if.slave bus
);
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic [W-1:0]   res;
  logic           brw;
  logic           busy;
  logic           done;
  logic [W-1:0]   diff;
  logic           b_out;
  logic           d_c;
  logic           brw_next_c;

  // Single full-subtractor cell working on the operand LSBs.
  always_comb begin
    d_c        = sa[0] ^ sb[0] ^ brw;
    brw_next_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
  end

`ifdef SERIAL_SUB4_OVF_EN
  logic ovf;
  assign bus.ovf = ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            brw   <= bus.b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          res <= {d_c, res[W-1:1]};
          sa  <= {1'b0, sa[W-1:1]};
          sb  <= {1'b0, sb[W-1:1]};
          brw <= brw_next_c;
          cnt <= cnt + CW'(1);
          // Last bit: publish the result; the borrow into bit 3 is still in brw.
          if (cnt == CW'(W - 1)) begin
            diff  <= {d_c, res[W-1:1]};
            b_out <= brw_next_c;
`ifdef SERIAL_SUB4_OVF_EN
            ovf   <= brw ^ brw_next_c;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.diff  = diff;
  assign bus.b_out = b_out;
endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: cycle-level reference model plus directed vectors.
// Define SERIAL_SUB4_OVF_EN to also check the overflow flag.
module tb_serial_sub4;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   checking = 1'b0;

  serial_sub4_if bus ();

  serial_sub4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts edges since accept (-1 = idle, 0..3 busy, 4 = done cycle).
  int         k = -1;
  logic [3:0] exp_diff = 4'h0, p_diff = 4'h0;
  logic       exp_bout = 1'b0, p_bout = 1'b0;
  logic       exp_ovf  = 1'b0, p_ovf  = 1'b0;

  always @(posedge clk) begin
    int r, sr;
    if (rst) begin
      k = -1; exp_diff = 4'h0; exp_bout = 1'b0; exp_ovf = 1'b0;
    end else if (k >= 0 && k < 3) begin
      k = k + 1;
    end else if (k == 3) begin
      k = 4; exp_diff = p_diff; exp_bout = p_bout; exp_ovf = p_ovf;
    end else if (bus.start === 1'b1) begin
      k      = 0;
      r      = int'(bus.a) - int'(bus.b) - int'(bus.b_in);
      p_diff = 4'(r);
      p_bout = (r < 0);
      sr     = int'($signed(bus.a)) - int'($signed(bus.b)) - int'(bus.b_in);
      p_ovf  = (sr < -8) || (sr > 7);
    end else begin
      k = -1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", int'(bus.busy), int'(k >= 0 && k <= 3));
      chk("done", int'(bus.done), int'(k == 4));
      chk("diff", int'(bus.diff), int'(exp_diff));
      chk("b_out", int'(bus.b_out), int'(exp_bout));
`ifdef SERIAL_SUB4_OVF_EN
      chk("ovf", int'(bus.ovf), int'(exp_ovf));
`endif
    end
  end

  // Issue one request and wait (bounded) for done; returns latency and busy-cycle count.
  task automatic run_req(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.b_in = bin;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 4'($urandom); bus.b = 4'($urandom); bus.b_in = 1'($urandom);
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done) begin lat = i; break; end
      if (bus.busy) bcnt++;
    end
    if (lat == 0) chk("req_timeout", 0, 1);
  endtask

  initial begin
    int lat, bcnt, ndone, last;
    rst = 1'b1; bus.start = 1'b0; bus.a = 4'h0; bus.b = 4'h0; bus.b_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_diff", int'(bus.diff), 0);
    rst = 1'b0;

    run_req(4'd9, 4'd4, 1'b0, lat, bcnt);
    chk("lat_9_4", lat, 4);
    chk("busy_cycles_9_4", bcnt, 4);
    chk("diff_9_4", int'(bus.diff), 5);
    chk("bout_9_4", int'(bus.b_out), 0);

    run_req(4'd3, 4'd5, 1'b0, lat, bcnt);
    chk("diff_3_5", int'(bus.diff), 14);
    chk("bout_3_5", int'(bus.b_out), 1);

    run_req(4'd0, 4'd0, 1'b1, lat, bcnt);
    chk("diff_0_0_1", int'(bus.diff), 15);
    chk("bout_0_0_1", int'(bus.b_out), 1);

    // start pulsed mid-operation must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd2; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd7; end
      if (i == 2) bus.start = 1'b0;
      if (bus.done) ndone++;
    end
    chk("ignored_start_dones", ndone, 1);
    chk("ignored_start_diff", int'(bus.diff), 4);

    // start held high: one result every 5 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd15; bus.b_in = 1'b0;
    ndone = 0; last = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        chk("b2b_diff", int'(bus.diff), 0);
        chk("b2b_bout", int'(bus.b_out), 0);
        if (last > 0) chk("b2b_period", i - last, 5);
        last = i;
      end
    end
    chk("b2b_dones", ndone, 4);
    bus.start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (!bus.busy && !bus.done) break;
      if (i == 10) chk("drain_timeout", 0, 1);
      @(negedge clk);
    end

    // Reset two cycles after accept aborts the operation
    run_req(4'd3, 4'd5, 1'b0, lat, bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd1; bus.b_in = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_diff", int'(bus.diff), 0);
    chk("abort_bout", int'(bus.b_out), 0);
    rst = 1'b0; bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_req(4'd9, 4'd4, 1'b0, lat, bcnt);
    chk("after_abort_lat", lat, 4);
    chk("after_abort_diff", int'(bus.diff), 5);

`ifdef SERIAL_SUB4_OVF_EN
    run_req(4'd8, 4'd1, 1'b0, lat, bcnt);
    chk("diff_8_1", int'(bus.diff), 7);
    chk("bout_8_1", int'(bus.b_out), 0);
    chk("ovf_8_1", int'(bus.ovf), 1);
    run_req(4'd7, 4'd1, 1'b0, lat, bcnt);
    chk("diff_7_1", int'(bus.diff), 6);
    chk("ovf_7_1", int'(bus.ovf), 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
